// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared definitions for the parking gate controller: FSM state
//               encodings, timebase rate and default tick-count constants.
// Contents    : state_t        - 2-bit FSM state type
//               ST_*           - FSM state encodings
//               TICK_HZ        - timebase pulse rate
//               DEF_*_TICKS    - default debounce / hold / timeout lengths
//               max_int()      - helper used to size shared counters
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  typedef logic [1:0] state_t;

  // Gate FSM encodings. ST_IDLE is the only state with the gate closed.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTER = 2'd1;
  localparam logic [1:0] ST_EXIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Timebase delivered on tick_100hz.
  localparam int TICK_HZ = 100;

  // Defaults expressed in timebase ticks.
  localparam int DEF_DEBOUNCE_TICKS = 3;
  localparam int DEF_HOLD_TICKS     = 2 * TICK_HZ;   // 2 s
  localparam int DEF_TIMEOUT_TICKS  = 10 * TICK_HZ;  // 10 s

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Tick-sampled debouncer for one raw car-detect sensor. The
//               filtered level follows the raw input only after
//               DEBOUNCE_TICKS consecutive tick samples at the new value, and
//               a registered one-cycle rise pulse follows each rising edge
//               of the filtered level.
// Ports       : clk_in      in   system clock
//               rst_n       in   synchronous active-low reset
//               tick_100hz  in   one-cycle sampling strobe
//               raw         in   unfiltered sensor, 1 = car present
//               level       out  debounced sensor level
//               rise        out  one-cycle pulse, one clk_in after level rises
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick_100hz,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  // Number of consecutive tick samples that disagreed with the current level.
  logic [CNT_W-1:0] disagree_cnt;
  // Level as seen one clock earlier, used to find the rising edge.
  logic             level_d;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      disagree_cnt <= '0;
      level        <= 1'b0;
      level_d      <= 1'b0;
      rise         <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;

      if (tick_100hz) begin
        if (raw == level) begin
          // Any agreeing sample breaks the run of disagreeing samples.
          disagree_cnt <= '0;
        end else if (disagree_cnt == CNT_LAST) begin
          level        <= raw;
          disagree_cnt <= '0;
        end else begin
          disagree_cnt <= disagree_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl
// Description : Single-gate car park controller. Debounces the entry and exit
//               lane sensors, opens the gate for one car at a time, keeps an
//               occupancy count with full/empty flags, holds the gate open
//               for a fixed time after the car clears, and raises a sticky
//               alarm if a sensor stays blocked too long with the gate open.
// Ports       : clk_in        in   system clock (only clock)
//               rst_n         in   synchronous active-low reset
//               tick_100hz    in   one-cycle timebase strobe
//               entry_sensor  in   raw entry-lane detect, 1 = car present
//               exit_sensor   in   raw exit-lane detect, 1 = car present
//               gate_open     out  gate actuator, 1 = open (registered)
//               occupancy     out  number of parked cars
//               full          out  occupancy == CAPACITY (registered)
//               empty         out  occupancy == 0 (registered)
//               alarm         out  sticky blocked-sensor timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY       = 16,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              tick_100hz,
  input  logic                              entry_sensor,
  input  logic                              exit_sensor,
  output logic                              gate_open,
  output logic [$clog2(CAPACITY + 1) - 1:0] occupancy,
  output logic                              full,
  output logic                              empty,
  output logic                              alarm
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  // One counter serves both the hold period and the blocked-sensor timeout,
  // so it is sized for whichever is longer.
  localparam int TCNT_W = $clog2(max_int(HOLD_TICKS, TIMEOUT_TICKS) + 1);

  localparam logic [OCC_W-1:0]  OCC_MAX      = OCC_W'(CAPACITY);
  localparam logic [TCNT_W-1:0] HOLD_LAST    = TCNT_W'(HOLD_TICKS - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_TICKS - 1);

  // --------------------------------------------------------------------------
  // Sensor conditioning
  // --------------------------------------------------------------------------
  logic entry_level;
  logic entry_rise;
  logic exit_level;
  logic exit_rise;

  sensor_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_entry_debounce (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_100hz (tick_100hz),
    .raw        (entry_sensor),
    .level      (entry_level),
    .rise       (entry_rise)
  );

  sensor_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_exit_debounce (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_100hz (tick_100hz),
    .raw        (exit_sensor),
    .level      (exit_level),
    .rise       (exit_rise)
  );

  // --------------------------------------------------------------------------
  // Gate FSM, tick counter and occupancy - next-state logic
  // --------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic [TCNT_W-1:0] tick_cnt;
  logic [TCNT_W-1:0] tick_cnt_nxt;
  logic [OCC_W-1:0]  occ_nxt;
  logic              alarm_nxt;

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    occ_nxt      = occupancy;
    alarm_nxt    = alarm;

    case (state)
      ST_IDLE: begin
        // Exit is checked first so a simultaneous entry pulse is dropped.
        // A pulse that cannot be served (exit while empty, entry while full)
        // is simply ignored.
        if (exit_rise && !empty) begin
          state_nxt = ST_EXIT;
        end else if (entry_rise && !full) begin
          state_nxt = ST_ENTER;
        end
      end

      ST_ENTER: begin
        if (!entry_level) begin
          // Car has cleared the entry lane: count it in.
          state_nxt = ST_HOLD;
          if (occupancy != OCC_MAX) begin
            occ_nxt = occupancy + OCC_W'(1);
          end
        end else if (tick_100hz) begin
          if (tick_cnt == TIMEOUT_LAST) begin
            alarm_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + TCNT_W'(1);
          end
        end
      end

      ST_EXIT: begin
        if (!exit_level) begin
          // Car has cleared the exit lane: count it out.
          state_nxt = ST_HOLD;
          if (occupancy != '0) begin
            occ_nxt = occupancy - OCC_W'(1);
          end
        end else if (tick_100hz) begin
          if (tick_cnt == TIMEOUT_LAST) begin
            alarm_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + TCNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        // Rise pulses are not looked at here; a car arriving during the
        // hold period has to present itself again after the gate closes.
        if (tick_100hz) begin
          if (tick_cnt == HOLD_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + TCNT_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Every state starts its own count from zero.
    if (state_nxt != state) begin
      tick_cnt_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers. The flags and the gate are registered from the next
  // values so they move on the same edge as occupancy and state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      alarm     <= 1'b0;
      gate_open <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      occupancy <= occ_nxt;
      full      <= (occ_nxt == OCC_MAX);
      empty     <= (occ_nxt == '0);
      alarm     <= alarm_nxt;
      gate_open <= (state_nxt != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_ctrl
// Description : Self-checking bench for parking_gate_ctrl with CAPACITY=2,
//               DEBOUNCE_TICKS=3, HOLD_TICKS=4, TIMEOUT_TICKS=8 and a tick
//               every 10 clocks. Directed table rows and hand sequences are
//               followed by random sensor activity checked cycle by cycle
//               against a behavioural model of the car park.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_ctrl;
  import parking_pkg::*;

  localparam int CAP  = 2;
  localparam int DEB  = 3;
  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tick   = 1'b0;
  logic       entry  = 1'b0;
  logic       exit_s = 1'b0;
  logic       gate;
  logic [1:0] occ;
  logic       full;
  logic       empty;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl #(
    .CAPACITY       (CAP),
    .DEBOUNCE_TICKS (DEB),
    .HOLD_TICKS     (HOLD),
    .TIMEOUT_TICKS  (TMO)
  ) dut (
    .clk_in       (clk),
    .rst_n        (rst_n),
    .tick_100hz   (tick),
    .entry_sensor (entry),
    .exit_sensor  (exit_s),
    .gate_open    (gate),
    .occupancy    (occ),
    .full         (full),
    .empty        (empty),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  // One-clock tick every 10 clocks.
  initial begin : g_tick
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div  = (div == 9) ? 0 : div + 1;
      tick = (div == 9);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Wait until n ticks have been seen by the DUT, let 3 more clocks settle,
  // and return at a falling edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: what the car park should look like after each edge.
  // --------------------------------------------------------------------------
  localparam int P_CLOSED = 0;  // gate shut, waiting for a car
  localparam int P_IN     = 1;  // car driving in
  localparam int P_OUT    = 2;  // car driving out
  localparam int P_AFTER  = 3;  // car gone, gate still open for a while

  bit m_valid = 0;
  int m_phase, m_pt, m_occ;
  bit m_alarm;
  bit m_lvl[2], m_prev[2], m_rise[2], m_last[2];
  int m_run[2];

  task automatic model_step();
    bit raw[2];
    raw[0] = entry;
    raw[1] = exit_s;
    if (!rst_n) begin
      m_valid = 1;
      m_phase = P_CLOSED; m_pt = 0; m_occ = 0; m_alarm = 0;
      for (int s = 0; s < 2; s++) begin
        m_lvl[s] = 0; m_prev[s] = 0; m_rise[s] = 0; m_last[s] = 0; m_run[s] = 0;
      end
      return;
    end
    case (m_phase)
      P_CLOSED: begin
        if (m_rise[1] && m_occ > 0) begin m_phase = P_OUT; m_pt = 0; end
        else if (m_rise[0] && m_occ < CAP) begin m_phase = P_IN; m_pt = 0; end
      end
      P_IN, P_OUT: begin
        if (!m_lvl[(m_phase == P_IN) ? 0 : 1]) begin
          if (m_phase == P_IN) m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
          else                 m_occ = (m_occ > 0) ? m_occ - 1 : m_occ;
          m_phase = P_AFTER; m_pt = 0;
        end else if (tick) begin
          m_pt++;
          if (m_pt == TMO) begin m_alarm = 1; m_phase = P_CLOSED; m_pt = 0; end
        end
      end
      default: begin
        if (tick) begin
          m_pt++;
          if (m_pt == HOLD) begin m_phase = P_CLOSED; m_pt = 0; end
        end
      end
    endcase
    // Debounce: level becomes the value of the latest DEB identical samples.
    for (int s = 0; s < 2; s++) begin
      bit r;
      r = m_lvl[s] && !m_prev[s];
      m_prev[s] = m_lvl[s];
      if (tick) begin
        if (raw[s] == m_last[s]) m_run[s]++;
        else begin m_last[s] = raw[s]; m_run[s] = 1; end
        if (m_run[s] >= DEB) m_lvl[s] = m_last[s];
      end
      m_rise[s] = r;
    end
  endtask

  initial begin : g_model
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Cycle-by-cycle scoreboard against the model.
  initial begin : g_scoreboard
    logic [5:0] exp_v;
    logic [5:0] got_v;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        exp_v = {m_phase != P_CLOSED, 2'(m_occ), m_occ == CAP, m_occ == 0, m_alarm};
        got_v = {gate, occ, full, empty, alarm};
        check("model{gate,occ,full,empty,alarm}", 32'(got_v), 32'(exp_v));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed vectors: drive sensors for n ticks, then check outputs.
  // --------------------------------------------------------------------------
  typedef struct {
    logic en;
    logic ex;
    int   n;
    logic g;
    int   o;
    logic f;
    logic e;
    logic a;
  } vec_t;

  vec_t vecs[14];

  initial begin : g_main
    vecs[0]  = '{1'b1, 1'b0, 3, 1'b1, 0, 1'b0, 1'b1, 1'b0};  // entry debounced -> open
    vecs[1]  = '{1'b1, 1'b0, 2, 1'b1, 0, 1'b0, 1'b1, 1'b0};  // still in lane
    vecs[2]  = '{1'b0, 1'b0, 3, 1'b1, 1, 1'b0, 1'b0, 1'b0};  // cleared -> hold, occ 1
    vecs[3]  = '{1'b0, 1'b0, 4, 1'b0, 1, 1'b0, 1'b0, 1'b0};  // hold over -> closed
    vecs[4]  = '{1'b1, 1'b0, 3, 1'b1, 1, 1'b0, 1'b0, 1'b0};  // second entry
    vecs[5]  = '{1'b0, 1'b0, 3, 1'b1, 2, 1'b1, 1'b0, 1'b0};  // occ 2, full
    vecs[6]  = '{1'b0, 1'b0, 4, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3, 1'b0, 2, 1'b1, 1'b0, 1'b0};  // entry while full ignored
    vecs[8]  = '{1'b0, 1'b0, 4, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3, 1'b1, 2, 1'b1, 1'b0, 1'b0};  // exit opens gate
    vecs[10] = '{1'b0, 1'b0, 3, 1'b1, 1, 1'b0, 1'b0, 1'b0};  // occ 1
    vecs[11] = '{1'b0, 1'b0, 4, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2, 1'b0, 1, 1'b0, 1'b0, 1'b0};  // 2-tick glitch
    vecs[13] = '{1'b0, 1'b0, 4, 1'b0, 1, 1'b0, 1'b0, 1'b0};  // no rise came of it

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_gate", gate, 0);
    check("reset_occ", occ, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_alarm", alarm, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      entry  = vecs[i].en;
      exit_s = vecs[i].ex;
      wait_ticks(vecs[i].n);
      check($sformatf("vec%0d_gate", i), gate, vecs[i].g);
      check($sformatf("vec%0d_occ", i), occ, vecs[i].o);
      check($sformatf("vec%0d_full", i), full, vecs[i].f);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].e);
      check($sformatf("vec%0d_alarm", i), alarm, vecs[i].a);
    end

    // Simultaneous entry and exit from occupancy 1: exit wins.
    entry = 1'b1; exit_s = 1'b1;
    wait_ticks(3);
    check("simul_state", dut.state, ST_EXIT);
    check("simul_gate", gate, 1);
    entry = 1'b0; exit_s = 1'b0;
    wait_ticks(3);
    check("simul_occ", occ, 0);
    check("simul_empty", empty, 1);
    wait_ticks(4);
    check("simul_closed", gate, 0);
    check("simul_occ_end", occ, 0);

    // Blocked entry sensor: alarm on the 8th tick spent in ENTER.
    entry = 1'b1;
    wait_ticks(10);
    check("tmo_alarm_pre", alarm, 0);
    check("tmo_gate_pre", gate, 1);
    wait_ticks(1);
    check("tmo_alarm", alarm, 1);
    check("tmo_gate", gate, 0);
    check("tmo_state", dut.state, ST_IDLE);
    check("tmo_occ", occ, 0);
    wait_ticks(1);
    entry = 1'b0;
    wait_ticks(4);
    check("tmo_alarm_sticky", alarm, 1);
    check("tmo_occ_end", occ, 0);

    // Reset during HOLD.
    entry = 1'b1;
    wait_ticks(3);
    entry = 1'b0;
    wait_ticks(3);
    check("rsthold_gate_pre", gate, 1);
    check("rsthold_occ_pre", occ, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rsthold_gate", gate, 0);
    check("rsthold_occ", occ, 0);
    check("rsthold_alarm", alarm, 0);
    check("rsthold_empty", empty, 1);
    check("rsthold_state", dut.state, ST_IDLE);
    rst_n = 1'b1;

    // Random sensor activity with occasional resets.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) entry = ~entry;
      if ($urandom_range(0, 39) == 0) exit_s = ~exit_s;
      rst_n = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 16: maximum number of parked cars.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 3: consecutive equal tick samples needed to accept a sensor level.
REQ-003 SHALL have parameter HOLD_TICKS, default 200: time the gate stays open after the car clears (2 s at 100 Hz).
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 1000: longest time a sensor may stay blocked while the gate is open (10 s).
REQ-005 SHALL have port clk_in, input, 1 bit: 100 MHz system clock, the only clock in the block.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous to clk_in, active-low.
REQ-007 SHALL have port tick_100hz, input, 1 bit: one-clk_in-wide timebase pulse from the 100 Hz divider.
REQ-008 SHALL have port entry_sensor, input, 1 bit: raw entry-lane car detect, 1 = car present.
REQ-009 SHALL have port exit_sensor, input, 1 bit: raw exit-lane car detect, 1 = car present.
REQ-010 SHALL have port gate_open, output, 1 bit: gate actuator, 1 = open.
REQ-011 SHALL have port occupancy, output, $clog2(CAPACITY+1) bits: number of cars parked.
REQ-012 SHALL have port full, output, 1 bit: asserted when occupancy == CAPACITY.
REQ-013 SHALL have port empty, output, 1 bit: asserted when occupancy == 0.
REQ-014 SHALL have port alarm, output, 1 bit: sticky flag for a blocked-sensor timeout.

Function
REQ-015 SHALL sample each raw sensor only on cycles where tick_100hz=1; the debounced level SHALL change only after DEBOUNCE_TICKS consecutive samples at the new value.
REQ-016 SHALL register a one-cycle rise pulse for each debounced sensor, one clk_in after the debounced level goes high.
REQ-017 SHALL implement the FSM states IDLE, ENTER, EXIT and HOLD; every transition SHALL take effect on the clk_in edge after its condition is true.
REQ-018 In IDLE, an exit rise pulse with occupancy>0 SHALL move the FSM to EXIT; an entry rise pulse with full=0 SHALL move it to ENTER.
REQ-019 If both rise pulses occur in the same cycle, exit SHALL take priority; the entry pulse SHALL be dropped.
REQ-020 An entry pulse while full=1 SHALL be ignored, and an exit pulse while empty=1 SHALL be ignored; occupancy SHALL stay unchanged in both cases.
REQ-021 gate_open SHALL be 1 in ENTER, EXIT and HOLD, and 0 in IDLE; it SHALL be driven directly from a register.
REQ-022 When the relevant debounced sensor returns low, ENTER SHALL increment occupancy by 1 and EXIT SHALL decrement it by 1, in the same edge that moves the FSM to HOLD.
REQ-023 occupancy SHALL never wrap past CAPACITY or below 0.
REQ-024 HOLD SHALL count HOLD_TICKS tick pulses and then return to IDLE; a new rise pulse during HOLD SHALL be ignored.
REQ-025 In ENTER or EXIT, if TIMEOUT_TICKS tick pulses pass with the sensor still high, the block SHALL set alarm and go to IDLE with occupancy unchanged.
REQ-026 alarm SHALL stay set until reset.
REQ-027 full and empty SHALL be registered, and SHALL change in the same cycle as occupancy.
REQ-028 The tick counter SHALL clear on every state change.

Reset
REQ-029 When rst_n=0 at a clk_in edge, the block SHALL set: FSM=IDLE, gate_open=0, occupancy=0, empty=1, full=0, alarm=0, debounced levels=0, debounce counters=0, tick counter=0.
REQ-030 Reset SHALL take precedence over all other events, including mid-ENTER and mid-HOLD; the gate SHALL close on the first edge with rst_n=0.

Structure
REQ-031 A shared package parking_pkg SHALL hold the FSM state encodings and the default tick constants (100 Hz, HOLD, TIMEOUT).
REQ-032 Debounce logic SHALL be one sub-module, sensor_debounce (ports: clk_in, rst_n, tick_100hz, raw, level, rise), used twice.

Verification (bench uses a tick every 10 clk_in, CAPACITY=2, DEBOUNCE_TICKS=3, HOLD_TICKS=4, TIMEOUT_TICKS=8)
REQ-033 Normal entry: hold entry_sensor high for 5 ticks, then drop it -> gate_open=1 after 3 ticks; occupancy 0->1 after the debounced level falls; gate_open=0 after 4 more ticks.
REQ-034 Full lane: two entries -> full=1, occupancy=2; a third entry pulse -> gate_open stays 0, occupancy stays 2.
REQ-035 Simultaneous events: from occupancy=1, raise both sensors on the same cycle -> FSM=EXIT, and occupancy ends at 0 with empty=1.
REQ-036 Timeout: hold entry_sensor high for 12 ticks -> alarm=1 at the 8th tick in ENTER, FSM=IDLE, occupancy unchanged.
REQ-037 Reset mid-operation: assert rst_n=0 during HOLD -> next edge gives gate_open=0, occupancy=0, alarm=0, FSM=IDLE.
REQ-038 Glitch filter: pulse entry_sensor high for 2 ticks only -> no rise pulse, gate_open stays 0.
